// File: rtl/prbs_pkg.sv
// Shared definitions for the 12-bit PRBS pattern loop; the generator imports the same package,
// so both ends of the loop use one polynomial.
package prbs_pkg;

  localparam int unsigned WIDTH = 12;
  localparam logic [WIDTH-1:0] TAP_MASK = 12'h829;

  typedef enum logic [1:0] {SEEK, TRAIN, LOCKED} state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAP_MASK)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising receive-side checker for the 12-bit LFSR test stream: acquires lock,
// free-runs the prediction and counts mismatches and checked words.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic [RUN_W-1:0] match_run_q, match_run_d;
  logic [RUN_W-1:0] miss_run_q, miss_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             match;
  logic             err_inc;
  logic             word_inc;

  assign match    = (data_in == pred_q);
  assign word_inc = data_valid && (state_q == LOCKED);
  assign err_inc  = word_inc && !match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEEK;
      pred_q      <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    if (data_valid) begin
      unique case (state_q)
        SEEK: begin
          // Zero is the LFSR lock-up value and can never seed a valid sequence.
          if (data_in != '0) begin
            pred_d      = lfsr_next(data_in);
            match_run_d = '0;
            state_d     = TRAIN;
          end
        end
        TRAIN: begin
          if (match) begin
            pred_d      = lfsr_next(pred_q);
            match_run_d = match_run_q + 1'b1;
            if (match_run_q == RUN_W'(LOCK_CNT - 1)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (data_in != '0) begin
            pred_d      = lfsr_next(data_in);
            match_run_d = '0;
          end else begin
            match_run_d = '0;
            state_d     = SEEK;
          end
        end
        LOCKED: begin
          // Prediction free-runs so a single corrupted word costs exactly one error.
          pred_d = lfsr_next(pred_q);
          if (match) begin
            miss_run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (miss_run_q == RUN_W'(UNLOCK_CNT - 1)) begin
              miss_run_d = '0;
              locked_d   = 1'b0;
              state_d    = SEEK;
            end else begin
              miss_run_d = miss_run_q + 1'b1;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(err_inc),
    .clr(clear),
    .q  (err_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_word_cnt (
    .clk(clk),
    .rst(rst),
    .inc(word_inc),
    .clr(clear),
    .q  (word_cnt)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker; a second instance with 4-bit counters exercises saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt, word_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4, word_cnt4;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [11:0] gen;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clear(clear),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .word_cnt(word_cnt4)
  );

  // x^12+x^6+x^4+x+1 written out tap by tap.
  function automatic logic [11:0] nxt(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

  // Present one word for exactly one rising edge; outputs are sampled 1 ns after that edge.
  task automatic step(input logic [11:0] w, input logic v);
    data_in    = w;
    data_valid = v;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(gen, 1'b1);
      gen = nxt(gen);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0h want 0", locked); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %0h want 0", err_pulse); else passed++;
    total++; if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); else passed++;
    total++; if (word_cnt !== 16'h0) $display("FAIL reset_word_cnt: got %0h want 0", word_cnt); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock;
    gen = 12'hFFF;
    send_clean(8);
    total++; if (locked !== 1'b0) $display("FAIL lock_early: got %0h want 0", locked); else passed++;
    send_clean(1);
    total++; if (locked !== 1'b1) $display("FAIL lock_rise: got %0h want 1", locked); else passed++;
    total++; if (word_cnt !== 16'd0) $display("FAIL lock_word0: got %0d want 0", word_cnt); else passed++;
    send_clean(5);
    total++; if (word_cnt !== 16'd5) $display("FAIL lock_word5: got %0d want 5", word_cnt); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL lock_err0: got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_single_error;
    step(gen ^ 12'h001, 1'b1);
    gen = nxt(gen);
    total++; if (err_pulse !== 1'b1) $display("FAIL single_pulse: got %0h want 1", err_pulse); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL single_err: got %0d want 1", err_cnt); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL single_locked: got %0h want 1", locked); else passed++;
    total++; if (word_cnt !== 16'd6) $display("FAIL single_word: got %0d want 6", word_cnt); else passed++;
    send_clean(1);
    total++; if (err_pulse !== 1'b0) $display("FAIL single_pulse_off: got %0h want 0", err_pulse); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL single_err_hold: got %0d want 1", err_cnt); else passed++;
    total++; if (word_cnt !== 16'd7) $display("FAIL single_word_next: got %0d want 7", word_cnt); else passed++;
  endtask

  task automatic test_unlock;
    for (int i = 0; i < 3; i++) begin
      step(gen ^ 12'h010, 1'b1);
      gen = nxt(gen);
    end
    total++; if (locked !== 1'b1) $display("FAIL unlock_3rd: got %0h want 1", locked); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL unlock_b2b_pulse: got %0h want 1", err_pulse); else passed++;
    step(gen ^ 12'h010, 1'b1);
    gen = nxt(gen);
    total++; if (locked !== 1'b0) $display("FAIL unlock_4th: got %0h want 0", locked); else passed++;
    total++; if (err_cnt !== 16'd5) $display("FAIL unlock_err: got %0d want 5", err_cnt); else passed++;
    total++; if (word_cnt !== 16'd11) $display("FAIL unlock_word: got %0d want 11", word_cnt); else passed++;
    send_clean(8);
    total++; if (locked !== 1'b0) $display("FAIL relock_early: got %0h want 0", locked); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL relock_pulse: got %0h want 0", err_pulse); else passed++;
    send_clean(1);
    total++; if (locked !== 1'b1) $display("FAIL relock: got %0h want 1", locked); else passed++;
    total++; if (err_cnt !== 16'd5) $display("FAIL relock_err_kept: got %0d want 5", err_cnt); else passed++;
    total++; if (word_cnt !== 16'd11) $display("FAIL relock_word_kept: got %0d want 11", word_cnt); else passed++;
  endtask

  task automatic test_zero;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(12'h000, 1'b1);
    total++; if (locked !== 1'b0) $display("FAIL zero_locked: got %0h want 0", locked); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL zero_err: got %0d want 0", err_cnt); else passed++;
    total++; if (word_cnt !== 16'd0) $display("FAIL zero_word: got %0d want 0", word_cnt); else passed++;
    // A zero word during training must drop back to SEEK, costing a fresh seed.
    gen = 12'hFFF;
    send_clean(4);
    step(12'h000, 1'b1);
    gen = nxt(gen);
    send_clean(8);
    total++; if (locked !== 1'b0) $display("FAIL zero_train_early: got %0h want 0", locked); else passed++;
    send_clean(1);
    total++; if (locked !== 1'b1) $display("FAIL zero_train_lock: got %0h want 1", locked); else passed++;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 16; i++) begin
      step(gen ^ 12'h800, 1'b1);
      gen = nxt(gen);
      send_clean(1);
    end
    total++; if (err_cnt4 !== 4'hF) $display("FAIL sat_err4: got %0h want f", err_cnt4); else passed++;
    total++; if (word_cnt4 !== 4'hF) $display("FAIL sat_word4: got %0h want f", word_cnt4); else passed++;
    total++; if (err_cnt !== 16'd16) $display("FAIL sat_err16: got %0d want 16", err_cnt); else passed++;
    total++; if (word_cnt !== 16'd32) $display("FAIL sat_word16: got %0d want 32", word_cnt); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL sat_locked: got %0h want 1", locked); else passed++;
    clear = 1'b1;
    step(gen ^ 12'h800, 1'b1);
    gen = nxt(gen);
    clear = 1'b0;
    total++; if (err_cnt !== 16'd0) $display("FAIL clr_err: got %0d want 0", err_cnt); else passed++;
    total++; if (err_cnt4 !== 4'h0) $display("FAIL clr_err4: got %0h want 0", err_cnt4); else passed++;
    total++; if (word_cnt !== 16'd0) $display("FAIL clr_word: got %0d want 0", word_cnt); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL clr_pulse: got %0h want 1", err_pulse); else passed++;
    send_clean(1);
    total++; if (word_cnt !== 16'd1) $display("FAIL clr_word_after: got %0d want 1", word_cnt); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL clr_locked: got %0h want 1", locked); else passed++;
  endtask

  task automatic test_gaps;
    logic [15:0] pat;
    pat = 16'b1011_0110_1101_0011;
    for (int i = 0; i < 16; i++) begin
      if (pat[i]) send_clean(1);
      else step(12'h5A5, 1'b0);
    end
    total++; if (err_cnt !== 16'd0) $display("FAIL gap_err: got %0d want 0", err_cnt); else passed++;
    total++; if (word_cnt !== 16'd11) $display("FAIL gap_word: got %0d want 11", word_cnt); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL gap_locked: got %0h want 1", locked); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (locked !== 1'b0) $display("FAIL rst_mid_locked: got %0h want 0", locked); else passed++;
    total++; if (word_cnt !== 16'd0) $display("FAIL rst_mid_word: got %0d want 0", word_cnt); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL rst_mid_pulse: got %0h want 0", err_pulse); else passed++;
    @(negedge clk);
    rst = 1'b0;
    send_clean(8);
    total++; if (locked !== 1'b0) $display("FAIL rst_relock_early: got %0h want 0", locked); else passed++;
    send_clean(1);
    total++; if (locked !== 1'b1) $display("FAIL rst_relock: got %0h want 1", locked); else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_zero();
    test_saturate();
    test_gaps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
